// File: rtl/rv32v_elem_sequencer.sv
// Two-lane vector element sequencer: walks element offsets for one vector
// instruction, two elements per beat, with stall back-pressure and flush abort.
module rv32v_elem_sequencer #(
   parameter int MAXELEM = 32,
   parameter int OFF_W   = 5
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             start,
   input  logic [31:0]      vl,
   input  logic             stall,
   input  logic             flush,
   output logic             ready,
   output logic             busy,
   output logic [OFF_W-1:0] woffset0,
   output logic [OFF_W-1:0] woffset1,
   output logic             wen0,
   output logic             wen1,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [31:0]    MAXELEM_32 = 32'(MAXELEM);
   localparam logic [OFF_W:0] MAXELEM_CW = (OFF_W+1)'(MAXELEM);

   state_t           state, state_nxt;
   logic [OFF_W:0]   cnt, cnt_nxt;
   logic [OFF_W:0]   vlr, vlr_nxt;
   logic [OFF_W:0]   vl_clamped;
   // One extra bit so cnt+1 / cnt+2 never wrap before the compare with vlr.
   logic [OFF_W+1:0] cnt_p1, cnt_p2, vlr_ext;

   assign vl_clamped = (vl > MAXELEM_32) ? MAXELEM_CW : vl[OFF_W:0];
   assign cnt_p1     = {1'b0, cnt} + (OFF_W+2)'(1);
   assign cnt_p2     = {1'b0, cnt} + (OFF_W+2)'(2);
   assign vlr_ext    = {1'b0, vlr};

   // State, element counter and latched length registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         cnt   <= '0;
         vlr   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         state <= state_nxt;
         cnt   <= cnt_nxt;
         vlr   <= vlr_nxt;
      end
   end

   // Next-state logic and beat outputs; flush overrides stall and start.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a signal unassigned, which would otherwise infer a latch.
      state_nxt = state;
      cnt_nxt   = cnt;
      vlr_nxt   = vlr;
      ready     = 1'b0;
      done      = 1'b0;
      wen0      = 1'b0;
      wen1      = 1'b0;
      woffset0  = '0;
      woffset1  = '0;

      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start && !flush) begin
               vlr_nxt   = vl_clamped;
               cnt_nxt   = '0;
               state_nxt = (vl_clamped != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            woffset0 = cnt[OFF_W-1:0];
            woffset1 = cnt_p1[OFF_W-1:0];
            if (!flush && !stall) begin
               wen0    = (cnt < vlr);
               wen1    = (cnt_p1 < vlr_ext);
               cnt_nxt = cnt_p2[OFF_W:0];
               if (cnt_p2 >= vlr_ext) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (flush) begin
         state_nxt = IDLE;
      end
   end

   assign busy = !ready;

endmodule
